// File: rtl/qed_pkg.sv
// Shared types and constants for the SQED commit sequencer.
package qed_pkg;

  typedef enum logic [1:0] {
    ORIG  = 2'd0,
    DRAIN = 2'd1,
    DUP   = 2'd2
  } qed_state_t;

  localparam int QED_REG_HALF = 16;

endpackage

// File: rtl/qed_sat_counter.sv
// Saturating up-counter; sat is high while the count sits at all-ones.
module qed_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/qed_commit_ctrl.sv
// SQED duplicate-execution sequencer: ORIG -> (DRAIN) -> DUP, commit counters, check qualifier.
// Optional drain timeout built when QED_DRAIN_TMO_EN is defined.
module qed_commit_ctrl
  import qed_pkg::*;
#(
  parameter int CNT_WIDTH  = 8,
  parameter int TMO_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exec_dup,
  input  logic                 issue_valid,
  input  logic                 commit_valid,
  input  logic                 commit_is_dup,
  output logic                 dup_mode,
  output logic                 issue_stall,
  output logic                 sif_commit,
  output logic                 sif_commit_pulsed,
  output logic                 qed_check_valid,
  output logic [CNT_WIDTH-1:0] orig_cnt,
  output logic [CNT_WIDTH-1:0] dup_cnt,
  output logic                 cnt_ovf,
  output logic                 drain_tmo
);

  localparam int IW = CNT_WIDTH + 1;

  qed_state_t    state, state_next;
  logic [IW-1:0] infl, infl_next;
  logic          issue_eff;
  logic          orig_commit;
  logic          tmo_hit;
  logic          sat_orig, sat_dup;

  // Issues seen while draining are protocol errors and must not grow the in-flight count.
  assign issue_eff   = issue_valid && (state != DRAIN);
  assign orig_commit = commit_valid && !commit_is_dup;

  always_comb begin
    infl_next = infl;
    if (issue_eff && !commit_valid) begin
      infl_next = infl + IW'(1);
    end else if (!issue_eff && commit_valid && (infl != '0)) begin
      infl_next = infl - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ORIG;
      infl  <= '0;
    end else begin
      state <= state_next;
      infl  <= infl_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ORIG:    if (exec_dup) state_next = (infl_next == '0) ? DUP : DRAIN;
      DRAIN:   if ((infl == '0) || tmo_hit) state_next = DUP;
      DUP:     state_next = DUP;
      default: state_next = ORIG;
    endcase
  end

  always_comb begin
    dup_mode    = (state == DUP);
    issue_stall = (state == DRAIN);
  end

`ifdef QED_DRAIN_TMO_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);

  logic [TW-1:0] tmr;
  logic          tmo_flag;

  assign tmo_hit   = (state == DRAIN) && (tmr == TW'(TMO_CYCLES - 1));
  assign drain_tmo = tmo_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr      <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmr      <= ((state == DRAIN) && (state_next == DRAIN)) ? tmr + TW'(1) : '0;
      tmo_flag <= tmo_flag | tmo_hit;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  // Constant 0; TMO_CYCLES only matters when the timeout is built.
  assign drain_tmo = (TMO_CYCLES < 0);
`endif

  qed_sat_counter #(.W(CNT_WIDTH)) u_orig_cnt (
    .clk (clk),
    .rst (rst),
    .inc (orig_commit),
    .cnt (orig_cnt),
    .sat (sat_orig)
  );

  qed_sat_counter #(.W(CNT_WIDTH)) u_dup_cnt (
    .clk (clk),
    .rst (rst),
    .inc (commit_valid && commit_is_dup),
    .cnt (dup_cnt),
    .sat (sat_dup)
  );

  // Counters never decrement, so saturation is already sticky until reset.
  assign cnt_ovf = sat_orig | sat_dup;

  always_ff @(posedge clk) begin
    if (rst) begin
      sif_commit        <= 1'b0;
      sif_commit_pulsed <= 1'b0;
      qed_check_valid   <= 1'b0;
    end else begin
      sif_commit        <= sif_commit | orig_commit;
      sif_commit_pulsed <= orig_commit && !sif_commit;
      qed_check_valid   <= (state == DUP) && (infl == '0) && (orig_cnt == dup_cnt) &&
                           (orig_cnt != '0) && !cnt_ovf;
    end
  end

endmodule

// File: tb/tb_qed_commit_ctrl.sv
// Directed bench for qed_commit_ctrl: default instance (a) plus a CNT_WIDTH=2/TMO_CYCLES=4 instance (b).
module tb_qed_commit_ctrl;

  logic clk = 1'b0;
  logic rst, exec_dup, issue_valid, commit_valid, commit_is_dup;

  logic       a_dup_mode, a_issue_stall, a_sif, a_pulse, a_qcv, a_ovf, a_tmo;
  logic [7:0] a_orig, a_dup;
  logic       b_dup_mode, b_issue_stall, b_sif, b_pulse, b_qcv, b_ovf, b_tmo;
  logic [1:0] b_orig, b_dup;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qed_commit_ctrl #(.CNT_WIDTH(8), .TMO_CYCLES(64)) dut_a (
    .clk(clk), .rst(rst), .exec_dup(exec_dup), .issue_valid(issue_valid),
    .commit_valid(commit_valid), .commit_is_dup(commit_is_dup),
    .dup_mode(a_dup_mode), .issue_stall(a_issue_stall), .sif_commit(a_sif),
    .sif_commit_pulsed(a_pulse), .qed_check_valid(a_qcv), .orig_cnt(a_orig),
    .dup_cnt(a_dup), .cnt_ovf(a_ovf), .drain_tmo(a_tmo)
  );

  qed_commit_ctrl #(.CNT_WIDTH(2), .TMO_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .exec_dup(exec_dup), .issue_valid(issue_valid),
    .commit_valid(commit_valid), .commit_is_dup(commit_is_dup),
    .dup_mode(b_dup_mode), .issue_stall(b_issue_stall), .sif_commit(b_sif),
    .sif_commit_pulsed(b_pulse), .qed_check_valid(b_qcv), .orig_cnt(b_orig),
    .dup_cnt(b_dup), .cnt_ovf(b_ovf), .drain_tmo(b_tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ed, input logic iv, input logic cv, input logic cd);
    exec_dup = ed; issue_valid = iv; commit_valid = cv; commit_is_dup = cd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    total++; if (a_dup_mode !== 1'b0)    begin bad++; $display("FAIL rst_dup_mode got=%b want=0", a_dup_mode); end
    total++; if (a_issue_stall !== 1'b0) begin bad++; $display("FAIL rst_issue_stall got=%b want=0", a_issue_stall); end
    total++; if (a_sif !== 1'b0)         begin bad++; $display("FAIL rst_sif got=%b want=0", a_sif); end
    total++; if (a_pulse !== 1'b0)       begin bad++; $display("FAIL rst_pulse got=%b want=0", a_pulse); end
    total++; if (a_qcv !== 1'b0)         begin bad++; $display("FAIL rst_qcv got=%b want=0", a_qcv); end
    total++; if (a_orig !== 8'd0)        begin bad++; $display("FAIL rst_orig got=%0d want=0", a_orig); end
    total++; if (a_dup !== 8'd0)         begin bad++; $display("FAIL rst_dup got=%0d want=0", a_dup); end
    total++; if (a_ovf !== 1'b0)         begin bad++; $display("FAIL rst_ovf got=%b want=0", a_ovf); end
    total++; if (a_tmo !== 1'b0)         begin bad++; $display("FAIL rst_tmo got=%b want=0", a_tmo); end
  endtask

  task automatic test_orig_then_dup();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 1, 0);
      step();
      total++; if (a_orig !== 8'(i)) begin bad++; $display("FAIL orig_cnt_%0d got=%0d want=%0d", i, a_orig, i); end
      total++; if (a_pulse !== (i == 1)) begin bad++; $display("FAIL pulse_%0d got=%b want=%b", i, a_pulse, (i == 1)); end
      total++; if (a_sif !== 1'b1) begin bad++; $display("FAIL sif_%0d got=%b want=1", i, a_sif); end
    end
    drive(1, 0, 0, 0);
    step();
    total++; if (a_dup_mode !== 1'b1)    begin bad++; $display("FAIL dup_mode_direct got=%b want=1", a_dup_mode); end
    total++; if (a_issue_stall !== 1'b0) begin bad++; $display("FAIL stall_direct got=%b want=0", a_issue_stall); end
    // Duplicates: check qualifier trails dup_cnt reaching orig_cnt by one cycle.
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 1, 1);
      step();
      total++; if (a_dup !== 8'(i)) begin bad++; $display("FAIL dup_cnt_%0d got=%0d want=%0d", i, a_dup, i); end
      total++; if (a_qcv !== 1'b0) begin bad++; $display("FAIL qcv_early_%0d got=%b want=0", i, a_qcv); end
    end
    drive(0, 0, 0, 0);
    step();
    total++; if (a_qcv !== 1'b1) begin bad++; $display("FAIL qcv_rise got=%b want=1", a_qcv); end
    step();
    total++; if (a_qcv !== 1'b1) begin bad++; $display("FAIL qcv_hold got=%b want=1", a_qcv); end
    drive(0, 1, 1, 0);
    step();
    drive(0, 0, 0, 0);
    total++; if (a_orig !== 8'd4) begin bad++; $display("FAIL orig_after_extra got=%0d want=4", a_orig); end
    step();
    total++; if (a_qcv !== 1'b0) begin bad++; $display("FAIL qcv_drop got=%b want=0", a_qcv); end
    total++; if (a_pulse !== 1'b0) begin bad++; $display("FAIL pulse_once got=%b want=0", a_pulse); end
  endtask

  task automatic test_drain();
    do_reset();
    drive(0, 1, 0, 0); step();
    drive(0, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    total++; if (a_issue_stall !== 1'b1) begin bad++; $display("FAIL drain_stall got=%b want=1", a_issue_stall); end
    total++; if (a_dup_mode !== 1'b0)    begin bad++; $display("FAIL drain_mode got=%b want=0", a_dup_mode); end
    drive(0, 1, 0, 0); step();
    drive(0, 0, 1, 0); step();
    total++; if (a_issue_stall !== 1'b1) begin bad++; $display("FAIL drain_stall_1left got=%b want=1", a_issue_stall); end
    drive(0, 0, 1, 0); step();
    total++; if (a_issue_stall !== 1'b1) begin bad++; $display("FAIL drain_stall_0left got=%b want=1", a_issue_stall); end
    total++; if (a_dup_mode !== 1'b0)    begin bad++; $display("FAIL drain_mode_0left got=%b want=0", a_dup_mode); end
    drive(0, 0, 0, 0); step();
    total++; if (a_dup_mode !== 1'b1)    begin bad++; $display("FAIL drain_to_dup got=%b want=1", a_dup_mode); end
    total++; if (a_issue_stall !== 1'b0) begin bad++; $display("FAIL drain_release got=%b want=0", a_issue_stall); end
    total++; if (a_orig !== 8'd2)        begin bad++; $display("FAIL drain_orig got=%0d want=2", a_orig); end
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0);
    total++; if (a_dup_mode !== 1'b1)    begin bad++; $display("FAIL dup_terminal got=%b want=1", a_dup_mode); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(0, 1, 0, 0); step();
    drive(0, 1, 0, 0); step();
    drive(1, 0, 1, 0); step();
    drive(0, 0, 0, 0);
    total++; if (a_pulse !== 1'b1)       begin bad++; $display("FAIL same_pulse got=%b want=1", a_pulse); end
    total++; if (a_issue_stall !== 1'b1) begin bad++; $display("FAIL same_drain got=%b want=1", a_issue_stall); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 1, 0);
      step();
      total++; if (b_orig !== 2'((i > 3) ? 3 : i)) begin bad++; $display("FAIL sat_orig_%0d got=%0d want=%0d", i, b_orig, (i > 3) ? 3 : i); end
      total++; if (b_ovf !== (i >= 3)) begin bad++; $display("FAIL sat_ovf_%0d got=%b want=%b", i, b_ovf, (i >= 3)); end
    end
    drive(1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1); step();
    end
    drive(0, 0, 0, 0);
    total++; if (b_dup !== 2'd3) begin bad++; $display("FAIL sat_dup got=%0d want=3", b_dup); end
    for (int i = 0; i < 4; i++) begin
      total++; if (b_qcv !== 1'b0) begin bad++; $display("FAIL sat_qcv_%0d got=%b want=0", i, b_qcv); end
      step();
    end
    total++; if (a_qcv !== 1'b0) begin bad++; $display("FAIL a_unequal_qcv got=%b want=0", a_qcv); end
  endtask

  task automatic test_drain_tmo();
    do_reset();
    drive(0, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0);
    repeat (3) step();
    total++; if (b_tmo !== 1'b0)         begin bad++; $display("FAIL tmo_early got=%b want=0", b_tmo); end
    total++; if (b_issue_stall !== 1'b1) begin bad++; $display("FAIL tmo_stall got=%b want=1", b_issue_stall); end
    step();
`ifdef QED_DRAIN_TMO_EN
    total++; if (b_tmo !== 1'b1)         begin bad++; $display("FAIL tmo_flag got=%b want=1", b_tmo); end
    total++; if (b_dup_mode !== 1'b1)    begin bad++; $display("FAIL tmo_dup got=%b want=1", b_dup_mode); end
`else
    total++; if (b_tmo !== 1'b0)         begin bad++; $display("FAIL tmo_off_flag got=%b want=0", b_tmo); end
    total++; if (b_issue_stall !== 1'b1) begin bad++; $display("FAIL tmo_off_wait got=%b want=1", b_issue_stall); end
`endif
  endtask

  task automatic test_rst_in_drain();
    do_reset();
    drive(0, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    total++; if (a_issue_stall !== 1'b1) begin bad++; $display("FAIL rd_in_drain got=%b want=1", a_issue_stall); end
    rst = 1'b1;
    drive(0, 0, 1, 0); step();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    total++; if (a_issue_stall !== 1'b0) begin bad++; $display("FAIL rd_stall got=%b want=0", a_issue_stall); end
    total++; if (a_dup_mode !== 1'b0)    begin bad++; $display("FAIL rd_mode got=%b want=0", a_dup_mode); end
    total++; if (a_orig !== 8'd0)        begin bad++; $display("FAIL rd_orig got=%0d want=0", a_orig); end
    total++; if (a_pulse !== 1'b0)       begin bad++; $display("FAIL rd_pulse got=%b want=0", a_pulse); end
    total++; if (a_sif !== 1'b0)         begin bad++; $display("FAIL rd_sif got=%b want=0", a_sif); end
    step();
    total++; if (a_pulse !== 1'b0)       begin bad++; $display("FAIL rd_pulse_after got=%b want=0", a_pulse); end
    total++; if (a_issue_stall !== 1'b0) begin bad++; $display("FAIL rd_stall_after got=%b want=0", a_issue_stall); end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    test_reset();
    test_orig_then_dup();
    test_drain();
    test_same_cycle();
    test_saturation();
    test_drain_tmo();
    test_rst_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
